// File: rtl/stdp_weight_updater.sv
// STDP weight updater for one pre/post neuron pair.
// Spikes are timestamped against a timestep counter that advances on
// each apply strobe. Pre/post pairs inside a linear window schedule a
// potentiation or depression. A short IDLE -> CALC -> COMMIT sequence
// applies that change to the owned weight, clamped to [w_min, w_max].

module stdp_weight_updater #(
    parameter int N      = 32,
    parameter int Q      = 16,
    parameter int TW     = 16,
    parameter int WINDOW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          apply,
    input  logic          enable_stdp,
    input  logic          pre_spike,
    input  logic          post_spike,
    input  logic [N-1:0]  weight_init,
    input  logic [N-1:0]  a_plus,
    input  logic [N-1:0]  a_minus,
    input  logic [N-1:0]  decay_step,
    input  logic [N-1:0]  w_min,
    input  logic [N-1:0]  w_max,
    output logic [N-1:0]  weight,
    output logic [TW-1:0] timestep,
    output logic          busy,
    output logic          done,
    output logic          overrun,
    output logic [N-1:0]  last_delta
);

    // The fraction must fit inside the word, and the timestep must fit
    // inside the datapath so that dt can be zero-extended into it.
    if (Q >= N || TW > N) begin : g_param_check
        $error("stdp_weight_updater: need Q < N and TW <= N");
    end

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        COMMIT
    } state_t;

    state_t          state;
    logic            pre_seen;
    logic            post_seen;
    logic [TW-1:0]   last_pre_t;
    logic [TW-1:0]   last_post_t;
    logic [TW-1:0]   dt_q;
    logic [N-1:0]    amp_q;
    logic [N-1:0]    mag_q;
    logic            neg_q;

    logic [TW-1:0]   dt_pre;
    logic [TW-1:0]   dt_post;
    logic            pot_hit;
    logic            dep_hit;
    logic            event_hit;
    logic [N-1:0]    prod;
    logic signed [N:0] sum;
    logic [N-1:0]    clamped;

    function automatic logic in_window(input logic [TW-1:0] dt);
        return (dt != '0) && (dt <= TW'(WINDOW));
    endfunction

    assign dt_pre  = timestep - last_pre_t;
    assign dt_post = timestep - last_post_t;

    // Pairing uses the flags and timestamps from before this step's captures;
    // simultaneous pre and post spikes never pair with each other.
    assign pot_hit   = apply && enable_stdp && post_spike && !pre_spike
                       && pre_seen && in_window(dt_pre);
    assign dep_hit   = apply && enable_stdp && pre_spike && !post_spike
                       && post_seen && in_window(dt_post);
    assign event_hit = pot_hit || dep_hit;

    assign prod = N'(dt_q) * decay_step;

    // Sign-extended add or subtract in N+1 bits, then clamp to the weight range.
    always_comb begin
        if (neg_q) begin
            sum = $signed({weight[N-1], weight}) - $signed({mag_q[N-1], mag_q});
        end else begin
            sum = $signed({weight[N-1], weight}) + $signed({mag_q[N-1], mag_q});
        end
        clamped = sum[N-1:0];
        if (sum > $signed({w_max[N-1], w_max})) begin
            clamped = w_max;
        end else if (sum < $signed({w_min[N-1], w_min})) begin
            clamped = w_min;
        end
    end

    // Timestamp capture, counter advance and the update FSM.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            weight      <= weight_init;
            timestep    <= '0;
            last_delta  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            overrun     <= 1'b0;
            pre_seen    <= 1'b0;
            post_seen   <= 1'b0;
            last_pre_t  <= '0;
            last_post_t <= '0;
            dt_q        <= '0;
            amp_q       <= '0;
            mag_q       <= '0;
            neg_q       <= 1'b0;
        end else begin
            if (apply) begin
                if (pre_spike) begin
                    last_pre_t <= timestep;
                    pre_seen   <= 1'b1;
                end
                if (post_spike) begin
                    last_post_t <= timestep;
                    post_seen   <= 1'b1;
                end
                timestep <= timestep + TW'(1);
                if (timestep == '1) begin
                    pre_seen  <= 1'b0;
                    post_seen <= 1'b0;
                end
            end

            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (event_hit) begin
                        dt_q  <= pot_hit ? dt_pre : dt_post;
                        amp_q <= pot_hit ? a_plus : a_minus;
                        neg_q <= !pot_hit;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    mag_q <= ($signed(prod) < $signed(amp_q)) ? (amp_q - prod) : '0;
                    done  <= 1'b1;
                    state <= COMMIT;
                end
                COMMIT: begin
                    weight     <= clamped;
                    last_delta <= clamped - weight;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase

            if (event_hit && state != IDLE) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule
